// File: rtl/des_pkg.sv
// Shared widths, idle filler and FSM state types for the DES byte packer.
package des_pkg;

    localparam int BLK_W  = 64;
    localparam int BYTE_W = 8;
    localparam int IDX_W  = $clog2(BLK_W / BYTE_W);
    localparam int LSB_W  = $clog2(BLK_W);

    localparam logic [BYTE_W-1:0] IDLE_FILL = 8'hFF;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } rx_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/des_byte_lane.sv
// Maps a byte index to the bit offset of its 8-bit lane inside a 64-bit block,
// honouring the byte order chosen by MSB_FIRST.
module des_byte_lane
    import des_pkg::*;
#(
    parameter int MSB_FIRST = 1
)
(
    input  logic [IDX_W-1:0] idx,
    output logic [LSB_W-1:0] lsb
);

    // With MSB_FIRST the first byte lives at bits [63:56], so the lane number
    // is the bitwise inverse of the index (7 - idx for a 3-bit index).
    assign lsb = {(MSB_FIRST != 0) ? ~idx : idx, 3'b000};

endmodule

// File: rtl/des_byte_packer.sv
// Byte-serial to 64-bit block packer (receive) and block to byte unpacker (transmit).
// Optional sticky overrun/underrun flags are built when DES_PACK_STATUS_EN is defined.
module des_byte_packer
    import des_pkg::*;
#(
    parameter int MSB_FIRST = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_vld,
    input  logic              byte_req,
    output logic [BYTE_W-1:0] byte_out,
    output logic [BLK_W-1:0]  blk_data,
    output logic              blk_vld,
    input  logic              blk_rdy,
    input  logic [BLK_W-1:0]  res_data,
    input  logic              res_vld,
    output logic              res_rdy
`ifdef DES_PACK_STATUS_EN
    ,
    output logic              ovr_err,
    output logic              udr_err
`endif
);

    rx_state_t         rx_state;
    tx_state_t         tx_state;
    logic [IDX_W-1:0]  rx_idx;
    logic [IDX_W-1:0]  tx_idx;
    logic [LSB_W-1:0]  rx_lsb;
    logic [LSB_W-1:0]  tx_lsb;
    logic [BLK_W-1:0]  hold;

    des_byte_lane #(.MSB_FIRST(MSB_FIRST)) u_rx_lane (.idx(rx_idx), .lsb(rx_lsb));
    des_byte_lane #(.MSB_FIRST(MSB_FIRST)) u_tx_lane (.idx(tx_idx), .lsb(tx_lsb));

    // Receive side: fill lanes in COLLECT, freeze the block in FULL until accepted.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every block sees pre-edge values.
        if (rst) begin
            rx_state <= COLLECT;
            rx_idx   <= '0;
            blk_data <= '0;
            blk_vld  <= 1'b0;
        end else begin
            case (rx_state)
                COLLECT: begin
                    if (byte_vld) begin
                        blk_data[rx_lsb +: BYTE_W] <= byte_in;
                        rx_idx <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) begin
                            rx_state <= FULL;
                            blk_vld  <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (blk_rdy) begin
                        rx_state <= COLLECT;
                        blk_vld  <= 1'b0;
                    end
                end
                default: rx_state <= COLLECT;
            endcase
        end
    end

    // Transmit side: res_rdy is registered so it stays low for one cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the holding register is a plain 64-bit register, so it is reset with everything else.
        if (rst) begin
            tx_state <= IDLE;
            tx_idx   <= '0;
            hold     <= '0;
            byte_out <= IDLE_FILL;
            res_rdy  <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (byte_req) byte_out <= IDLE_FILL;
                    if (res_vld && res_rdy) begin
                        hold     <= res_data;
                        tx_idx   <= '0;
                        tx_state <= SEND;
                        res_rdy  <= 1'b0;
                    end else begin
                        res_rdy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (byte_req) begin
                        byte_out <= hold[tx_lsb +: BYTE_W];
                        tx_idx   <= tx_idx + 3'd1;
                        if (tx_idx == 3'd7) begin
                            tx_state <= IDLE;
                            res_rdy  <= 1'b1;
                        end
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

`ifdef DES_PACK_STATUS_EN
    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_err <= 1'b0;
            udr_err <= 1'b0;
        end else begin
            if (rx_state == FULL && byte_vld) ovr_err <= 1'b1;
            if (tx_state == IDLE && byte_req) udr_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/des_byte_packer.md
DES_BYTE_PACKER -- requirements
Module: des_byte_packer

Interface
REQ-001 Parameter MSB_FIRST, default 1, byte order: 1 = first byte on bits [63:56]; 0 = first byte on bits [7:0].
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 byte_in  input  8  received byte from serial adapter.
REQ-005 byte_vld  input  1  one-cycle strobe, byte_in valid (serial adapter output-ready flag).
REQ-006 byte_req  input  1  one-cycle strobe, serial adapter requests next transmit byte (input-ready flag).
REQ-007 byte_out  output  8  transmit byte to serial adapter.
REQ-008 blk_data  output  64  assembled plaintext block to DES core.
REQ-009 blk_vld  output  1  blk_data valid; held until accepted.
REQ-010 blk_rdy  input  1  DES core accepts block when blk_vld and blk_rdy both high.
REQ-011 res_data  input  64  DES result block.
REQ-012 res_vld  input  1  res_data valid.
REQ-013 res_rdy  output  1  packer accepts result when res_vld and res_rdy both high.

Function
REQ-014 Receive FSM SHALL have states COLLECT and FULL; 3-bit byte index rx_idx.
REQ-015 In COLLECT, each byte_vld SHALL write byte_in into lane rx_idx (order per MSB_FIRST) and increment rx_idx.
REQ-016 On the eighth byte (rx_idx = 7), rx_idx SHALL wrap to 0 and FSM SHALL enter FULL; blk_vld SHALL go high the next cycle.
REQ-017 In FULL, blk_data and blk_vld SHALL be stable; blk_vld and blk_rdy high SHALL return FSM to COLLECT, blk_vld low next cycle.
REQ-018 byte_vld in FULL SHALL be dropped, block unchanged (overrun).
REQ-019 byte_vld in the same cycle as handshake in FULL SHALL also be dropped.
REQ-020 Transmit FSM SHALL have states IDLE and SEND; 3-bit index tx_idx.
REQ-021 res_rdy SHALL be high exactly in IDLE; handshake SHALL latch res_data into a 64-bit holding register, set tx_idx = 0, enter SEND.
REQ-022 In SEND, each byte_req SHALL drive byte_out with lane tx_idx (same order as REQ-015) on the next cycle and increment tx_idx; byte_out SHALL hold until the next byte_req.
REQ-023 After the byte with tx_idx = 7 is presented, FSM SHALL return to IDLE, tx_idx wraps to 0.
REQ-024 byte_req in IDLE SHALL drive byte_out = 8'hFF (idle filler, underrun).
REQ-025 Receive and transmit FSMs SHALL be independent; simultaneous byte_vld and byte_req SHALL both be serviced in the same cycle.
REQ-026 Latency: byte_req to byte_out update exactly 1 cycle; eighth byte_vld to blk_vld exactly 1 cycle.

Reset
REQ-027 rst high SHALL immediately force COLLECT, IDLE, rx_idx = tx_idx = 0, blk_data = 0, blk_vld = 0, res_rdy = 0 while asserted, byte_out = 8'hFF, holding register = 0.
REQ-028 rst mid-block SHALL discard partial input and remaining output bytes; res_rdy SHALL rise the first cycle after rst deasserts.

Configuration
REQ-029 With DES_PACK_STATUS_EN defined, outputs ovr_err and udr_err (1 bit each) SHALL exist: sticky flags set by REQ-018/019 and REQ-024 respectively, cleared only by rst.
REQ-030 Without DES_PACK_STATUS_EN, those ports and their logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-031 Shared package des_pkg SHALL hold the block width (64), byte width (8), idle filler 8'hFF, and the rx/tx state enumerations.
REQ-032 Lane select/insert SHALL be one sub-module des_byte_lane (index, MSB_FIRST to 8-bit slice), instantiated for receive and transmit.

Verification
REQ-033 Bytes 01..08 on byte_vld, blk_rdy high -> blk_data = 64'h0102030405060708 (MSB_FIRST=1), blk_vld high one cycle.
REQ-034 Same with MSB_FIRST=0 -> blk_data = 64'h0807060504030201.
REQ-035 blk_rdy low, 9th byte 0xAA sent -> blk_data unchanged, ovr_err = 1 (status enabled).
REQ-036 res_data = 64'h85E813540F0AB405 accepted, 9 byte_req -> byte_out 85,E8,13,54,0F,0A,B4,05 then FF, udr_err = 1, res_rdy high after 8th.
REQ-037 rst pulsed after 4 bytes in and 3 bytes out -> all outputs at REQ-027 values; next 8 bytes form a fresh block.
REQ-038 byte_vld and byte_req in the same cycle across a full exchange -> both streams correct, no lost bytes.
